board_io_ctrl: RTL

- Board-level I/O conditioning block for the FPGA tops (nano20k and successors); sits between the raw board pins and the tinyQV core.
- Debounces the push-buttons and turns them into a stretched, synchronous core reset.
- Drives a parametrised bank of active-low LEDs. Each LED has a per-channel mode: off, direct, pulse-stretched activity or heartbeat.
- Replaces the ad-hoc button-OR reset and the fixed blink counter with a reusable, parameter-sized block.

---
 rtl/board_io_ctrl.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/board_io_ctrl.sv
// -----------------------------------------------------------------------------
// board_io_ctrl
//
// Board-level I/O conditioning between the raw board pins and the core:
//   - 2-FF synchronisers on the raw buttons and on the LED activity inputs
//   - per-button debounce, and a reset FSM that holds the core in reset while
//     any button is pressed plus RESET_HOLD_CYCLES after the last release
//   - a bank of active-low LEDs, each with a mode: off, direct, stretched
//     activity or heartbeat
//
// Optional build macro BOARD_IO_TEST_LEDS_EN: when defined, the LEDs ignore
// mode_i/act_i and show a single lit LED walking one channel per heartbeat
// toggle. Debounce and reset generation are unchanged.
//
// Ports:
//   clk          core clock
//   rst_n        asynchronous active-low reset, clears every flop
//   btn_i        raw active-high buttons (asynchronous)
//   act_i        per-channel activity level (asynchronous, active-high)
//   mode_i       per-channel mode, channel k at [2k+1:2k]
//                (00 off, 01 direct, 10 stretched, 11 heartbeat)
//   led_o        LED drive, active-low (1 = off)
//   btn_db_o     debounced button levels
//   sys_rst_n_o  synchronous active-low core reset
// -----------------------------------------------------------------------------
module board_io_ctrl #(
    parameter int NUM_LEDS          = 6,
    parameter int NUM_BTNS          = 2,
    parameter int DEBOUNCE_CYCLES   = 640000,
    parameter int STRETCH_CYCLES    = 3200000,
    parameter int HB_HALF_CYCLES    = 32000000,
    parameter int RESET_HOLD_CYCLES = 65536
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_BTNS-1:0]   btn_i,
    input  logic [NUM_LEDS-1:0]   act_i,
    input  logic [2*NUM_LEDS-1:0] mode_i,
    output logic [NUM_LEDS-1:0]   led_o,
    output logic [NUM_BTNS-1:0]   btn_db_o,
    output logic                  sys_rst_n_o
);

    // Counter widths sized to the largest value each counter holds.
    localparam int DB_W   = (DEBOUNCE_CYCLES > 1)   ? $clog2(DEBOUNCE_CYCLES)   : 1;
    localparam int ST_W   = $clog2(STRETCH_CYCLES + 1);
    localparam int HB_W   = (HB_HALF_CYCLES > 1)    ? $clog2(HB_HALF_CYCLES)    : 1;
    localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0]   ST_LOAD   = ST_W'(STRETCH_CYCLES);
    localparam logic [HB_W-1:0]   HB_LAST   = HB_W'(HB_HALF_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HOLD_BTN  = 2'd1,
        HOLD_TIME = 2'd2
    } state_t;

    // ---------------- synchronisers and debounce ----------------
    logic [NUM_BTNS-1:0] btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
    logic [NUM_LEDS-1:0] act_s1_q, act_s1_d, act_s2_q, act_s2_d;
    logic [NUM_BTNS-1:0] btn_db_q, btn_db_d;
    logic [DB_W-1:0]     db_cnt_q [NUM_BTNS];
    logic [DB_W-1:0]     db_cnt_d [NUM_BTNS];

    always_comb begin
        btn_s1_d = btn_i;
        btn_s2_d = btn_s1_q;
        act_s1_d = act_i;
        act_s2_d = act_s1_q;
        btn_db_d = btn_db_q;
        for (int b = 0; b < NUM_BTNS; b++) begin
            db_cnt_d[b] = db_cnt_q[b];
            if (btn_s2_q[b] != btn_db_q[b]) begin
                // The level must disagree for DEBOUNCE_CYCLES consecutive
                // cycles; any agreeing cycle restarts the count.
                if (db_cnt_q[b] == DB_LAST) begin
                    btn_db_d[b] = ~btn_db_q[b];
                    db_cnt_d[b] = '0;
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + 1'b1;
                end
            end else begin
                db_cnt_d[b] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q <= '0;
            btn_s2_q <= '0;
            act_s1_q <= '0;
            act_s2_q <= '0;
            btn_db_q <= '0;
            for (int b = 0; b < NUM_BTNS; b++) begin
                db_cnt_q[b] <= '0;
            end
        end else begin
            btn_s1_q <= btn_s1_d;
            btn_s2_q <= btn_s2_d;
            act_s1_q <= act_s1_d;
            act_s2_q <= act_s2_d;
            btn_db_q <= btn_db_d;
            for (int b = 0; b < NUM_BTNS; b++) begin
                db_cnt_q[b] <= db_cnt_d[b];
            end
        end
    end

    // ---------------- reset FSM ----------------
    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                sys_rst_q, sys_rst_d;
    logic                any_btn;

    assign any_btn = |btn_db_q;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            RUN: begin
                if (any_btn) state_d = HOLD_BTN;
            end
            HOLD_BTN: begin
                if (!any_btn) begin
                    state_d    = HOLD_TIME;
                    hold_cnt_d = '0;
                end
            end
            HOLD_TIME: begin
                // A new press restarts the whole hold sequence.
                if (any_btn) begin
                    state_d = HOLD_BTN;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = RUN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = HOLD_TIME;
                hold_cnt_d = '0;
            end
        endcase
        // Registered from next_state so the reset edge lines up with the
        // state transition rather than lagging it by a cycle.
        sys_rst_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HOLD_TIME;
            hold_cnt_q <= '0;
            sys_rst_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            sys_rst_q  <= sys_rst_d;
        end
    end

    // ---------------- stretch, heartbeat and LED drive ----------------
    logic [ST_W-1:0]     st_cnt_q [NUM_LEDS];
    logic [ST_W-1:0]     st_cnt_d [NUM_LEDS];
    logic [HB_W-1:0]     hb_cnt_q, hb_cnt_d;
    logic                hb_q, hb_d;
    logic                hb_wrap;
    logic [NUM_LEDS-1:0] led_q, led_d;

    assign hb_wrap = (hb_cnt_q == HB_LAST);

    always_comb begin
        for (int k = 0; k < NUM_LEDS; k++) begin
            // Retriggerable, saturating at zero.
            if (act_s2_q[k]) begin
                st_cnt_d[k] = ST_LOAD;
            end else if (st_cnt_q[k] != '0) begin
                st_cnt_d[k] = st_cnt_q[k] - 1'b1;
            end else begin
                st_cnt_d[k] = '0;
            end
        end
        hb_cnt_d = hb_wrap ? '0 : hb_cnt_q + 1'b1;
        hb_d     = hb_wrap ? ~hb_q : hb_q;
    end

`ifdef BOARD_IO_TEST_LEDS_EN
    localparam int WALK_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [WALK_W-1:0] WALK_LAST = WALK_W'(NUM_LEDS - 1);

    logic [WALK_W-1:0] walk_idx_q, walk_idx_d;

    always_comb begin
        walk_idx_d = walk_idx_q;
        if (hb_wrap) begin
            walk_idx_d = (walk_idx_q == WALK_LAST) ? '0 : walk_idx_q + 1'b1;
        end
        for (int k = 0; k < NUM_LEDS; k++) begin
            led_d[k] = (walk_idx_q != WALK_W'(k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            walk_idx_q <= '0;
        end else begin
            walk_idx_q <= walk_idx_d;
        end
    end
`else
    logic [NUM_LEDS-1:0] lit;

    always_comb begin
        lit = '0;
        for (int k = 0; k < NUM_LEDS; k++) begin
            case (mode_i[2*k +: 2])
                2'b01:   lit[k] = act_s2_q[k];
                2'b10:   lit[k] = (st_cnt_q[k] != '0) | act_s2_q[k];
                2'b11:   lit[k] = hb_q;
                default: lit[k] = 1'b0;
            endcase
        end
        led_d = ~lit;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_LEDS; k++) begin
                st_cnt_q[k] <= '0;
            end
            hb_cnt_q <= '0;
            hb_q     <= 1'b0;
            led_q    <= '1;
        end else begin
            for (int k = 0; k < NUM_LEDS; k++) begin
                st_cnt_q[k] <= st_cnt_d[k];
            end
            hb_cnt_q <= hb_cnt_d;
            hb_q     <= hb_d;
            led_q    <= led_d;
        end
    end

    assign led_o       = led_q;
    assign btn_db_o    = btn_db_q;
    assign sys_rst_n_o = sys_rst_q;

endmodule
